// File: rtl/fifo_wconv_pkg.sv
// ============================================================
// fifo_wconv_pkg : shared defaults, width helpers for fifo_wconv
// Rev 1.0
// ============================================================
`default_nettype none

package fifo_wconv_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int DEF_WR_W     = 8;
  localparam int DEF_RATIO    = 2;
  localparam int DEF_RD_DEPTH = 128;
  localparam int DEF_AF_LVL   = DEF_RD_DEPTH - 4;
  localparam int DEF_AE_LVL   = 4;

  localparam int DEF_RD_W  = DEF_WR_W * DEF_RATIO;
  localparam int DEF_PTR_W = clog2(DEF_RD_DEPTH);
  localparam int DEF_RUW   = clog2(DEF_RD_DEPTH) + 1;
  localparam int DEF_WUW   = clog2(DEF_RD_DEPTH * DEF_RATIO) + 1;

endpackage

`default_nettype wire

// File: rtl/fifo_ram_sdp.sv
// ============================================================
// fifo_ram_sdp : simple dual-port RAM, registered read port
// Rev 1.0
// ============================================================
`default_nettype none

module fifo_ram_sdp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wconv.sv
// ============================================================
// fifo_wconv : single-clock FIFO, narrow writes packed to wide reads
// Rev 1.0
// ============================================================
`default_nettype none

module fifo_wconv
  import fifo_wconv_pkg::*;
#(
  parameter int WR_W     = DEF_WR_W,
  parameter int RATIO    = DEF_RATIO,
  parameter int RD_DEPTH = DEF_RD_DEPTH,
  parameter int AF_LVL   = RD_DEPTH - 4,
  parameter int AE_LVL   = DEF_AE_LVL
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              wr_req,
  input  logic [WR_W-1:0]                   wr_data,
  input  logic                              wr_flush,
  input  logic                              rd_req,
  output logic [WR_W*RATIO-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              wr_full,
  output logic                              rd_empty,
  output logic [clog2(RD_DEPTH*RATIO):0]    wr_usedw,
  output logic [clog2(RD_DEPTH):0]          rd_usedw,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              wr_ovf,
  output logic                              rd_unf
);

  localparam int RD_W  = WR_W * RATIO;
  localparam int AW    = clog2(RD_DEPTH);
  localparam int LOG_R = clog2(RATIO);
  localparam int PCW   = (LOG_R == 0) ? 1 : LOG_R;
  localparam int RUW   = AW + 1;
  localparam int WUW   = clog2(RD_DEPTH * RATIO) + 1;

  localparam logic [RUW-1:0] C_FULL    = RUW'(RD_DEPTH);
  localparam logic [RUW-1:0] C_AF      = RUW'(AF_LVL);
  localparam logic [RUW-1:0] C_AE      = RUW'(AE_LVL);
  localparam logic [PCW-1:0] LAST_LANE = PCW'(RATIO - 1);

  logic [RD_W-1:0] pack_q, pack_d;
  logic [PCW-1:0]  pack_cnt_q, pack_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [RUW-1:0]  rd_usedw_q, rd_usedw_d;
  logic            wr_ovf_q, rd_unf_q, rd_valid_q;

  logic            wr_acc, rd_acc;
  logic            full_commit, flush_commit, commit;
  logic [RD_W-1:0] pack_word;

  assign wr_full      = (rd_usedw_q == C_FULL);
  assign rd_empty     = (rd_usedw_q == '0);
  assign almost_full  = (rd_usedw_q >= C_AF);
  assign almost_empty = (rd_usedw_q <= C_AE);
  assign rd_usedw     = rd_usedw_q;
  // RATIO is a power of two, so the shift is exact and pack_cnt fits below it.
  assign wr_usedw     = (WUW'(rd_usedw_q) << LOG_R) + WUW'(pack_cnt_q);
  assign wr_ovf       = wr_ovf_q;
  assign rd_unf       = rd_unf_q;
  assign rd_valid     = rd_valid_q;

  always_comb begin
    wr_acc    = wr_req && !wr_full;
    rd_acc    = rd_req && !rd_empty;
    pack_word = pack_q;
    if (wr_acc) begin
      pack_word[int'(pack_cnt_q)*WR_W +: WR_W] = wr_data;
    end
    full_commit  = wr_acc && (pack_cnt_q == LAST_LANE);
    // Flush sees the lane written this same cycle; unfilled lanes are already zero.
    flush_commit = wr_flush && !full_commit && !wr_full && (wr_acc || (pack_cnt_q != '0));
    commit       = full_commit || flush_commit;

    pack_d     = commit ? '0 : pack_word;
    pack_cnt_d = pack_cnt_q;
    if (commit) begin
      pack_cnt_d = '0;
    end else if (wr_acc) begin
      pack_cnt_d = pack_cnt_q + 1'b1;
    end

    wr_ptr_d   = wr_ptr_q + AW'(commit);
    rd_ptr_d   = rd_ptr_q + AW'(rd_acc);
    rd_usedw_d = rd_usedw_q + RUW'(commit) - RUW'(rd_acc);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pack_q     <= '0;
      pack_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_usedw_q <= '0;
      wr_ovf_q   <= 1'b0;
      rd_unf_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_usedw_q <= rd_usedw_d;
      wr_ovf_q   <= wr_req && wr_full;
      rd_unf_q   <= rd_req && rd_empty;
      rd_valid_q <= rd_acc;
    end
  end

  fifo_ram_sdp #(
    .DATA_W (RD_W),
    .DEPTH  (RD_DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .we_i    (commit),
    .waddr_i (wr_ptr_q),
    .wdata_i (pack_word),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

endmodule

`default_nettype wire

// File: doc/fifo_wconv.md
Name: fifo_wconv

Overview:
Single-clock FIFO that accepts narrow write words and delivers wide read words (RATIO narrow words packed per read word). It is the parametrised successor to the team's fixed 8-in/16-out FIFO. It adds configurable width ratio, depth, almost-full/almost-empty levels, partial-word flush and overflow/underflow pulses. It sits between byte-oriented producers (UART/ADC capture) and word-oriented consumers (SDRAM/display write paths) inside one clock domain.

Parameters:
WR_W, 8, write data width in bits (>=1)
RATIO, 2, read width / write width; power of 2, 1..8; RD_W = WR_W*RATIO
RD_DEPTH, 128, storage depth in read (wide) words; power of 2, >=4
AF_LVL, RD_DEPTH-4, rd_usedw level at/above which almost_full asserts
AE_LVL, 4, rd_usedw level at/below which almost_empty asserts

Ports:
sys_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  synchronous active-high reset
wr_req  in  1  write one narrow word this cycle
wr_data  in  WR_W  narrow write data
wr_flush  in  1  push the partial pack word to storage, zero-padded
rd_req  in  1  read one wide word this cycle
rd_data  out  RD_W  wide read data, registered
rd_valid  out  1  rd_data updated this cycle
wr_full  out  1  no narrow write can be accepted
rd_empty  out  1  no complete wide word available
wr_usedw  out  clog2(RD_DEPTH*RATIO)+1  narrow words held (stored + packing)
rd_usedw  out  clog2(RD_DEPTH)+1  wide words stored
almost_full  out  1  rd_usedw >= AF_LVL
almost_empty  out  1  rd_usedw <= AE_LVL
wr_ovf  out  1  one-cycle pulse: wr_req while wr_full (word dropped)
rd_unf  out  1  one-cycle pulse: rd_req while rd_empty (ignored)

Behaviour:
- Clock and reset: one clock (sys_clk); reset (sys_rst) is synchronous and active-high. Reset applies on a rising edge with sys_rst=1 and overrides all inputs, including mid-operation. Reset clears pointers, counts, pack register, pack_cnt, rd_data=0 and rd_valid=0. After reset: rd_empty=1, wr_full=0, almost_empty=1, almost_full=0, wr_ovf=0, rd_unf=0.
- Packing:
  - Accepted narrow write k (k = pack_cnt, 0..RATIO-1) fills lane k, bits [k*WR_W +: WR_W]. The first-written word lands in the LSBs.
  - When lane RATIO-1 is filled, the wide word is committed to storage in the same edge and pack_cnt returns to 0.
  - RATIO=1 degenerates to a plain FIFO.
- Write acceptance: wr_req && !wr_full. Otherwise the word is dropped and wr_ovf pulses the next cycle.
- Full condition: wr_full = (rd_usedw == RD_DEPTH). Packing only occurs when storage is not full, so wr_usedw max = RD_DEPTH*RATIO exactly.
- Flush:
  - wr_flush with pack_cnt>0 (after including a same-cycle accepted wr_req) commits the partial word with unfilled lanes = 0.
  - wr_usedw rounds up to the next multiple of RATIO.
  - wr_flush with pack_cnt==0 (after same-cycle write) is a no-op.
- Read:
  - Acceptance is rd_req && !rd_empty.
  - rd_data is loaded with the oldest wide word on the following edge (latency 1) and rd_valid=1 for that one cycle.
  - rd_data holds its value otherwise.
  - rd_req while empty: no state change, rd_unf pulses the next cycle.
- Simultaneous commit and read: a commit (full pack or flush) and a read in the same cycle leave rd_usedw unchanged. A read when full plus any write is legal: the read is accepted, the write is dropped (full at that edge).
- Flag timing: all flags and counts are registered and reflect state after the current edge. rd_empty deasserts the cycle after the first commit.
- Counts: rd_usedw = wide words stored. wr_usedw = rd_usedw*RATIO + pack_cnt. Pointers wrap modulo RD_DEPTH.

Decomposition:
- Package fifo_wconv_pkg holds:
  - clog2 function
  - derived-width constants (RD_W, pointer width, count widths)
  - default parameter values
- Sub-module fifo_ram_sdp: simple dual-port RAM, RD_W x RD_DEPTH, one write port, registered read port. It provides the rd_data register and infers M9K.

Test Plan:
- Reset then 4 writes 0x01..0x04 (RATIO=2), then 2 reads -> rd_data 0x0201 then 0x0403, each with a rd_valid pulse; rd_empty=1 afterwards.
- Write RD_DEPTH*RATIO=256 words -> wr_full=1, wr_usedw=256, almost_full=1; a 257th write -> wr_ovf pulse, data absent on readback.
- Write 3 words 0xA1,0xA2,0xA3 then wr_flush -> reads return 0xA2A1 then 0x00A3; wr_usedw goes 3 -> 4 on flush.
- At full: rd_req and wr_req in the same cycle -> read accepted, write dropped with wr_ovf, rd_usedw=RD_DEPTH-1, wr_full=0 next cycle.
- At rd_usedw=5: a completing write and rd_req in the same cycle -> rd_usedw stays 5; pointer wrap over 3*RD_DEPTH streaming words shows no data loss (counting pattern matches).
- rd_req on empty -> rd_unf pulse, rd_data unchanged. sys_rst asserted mid-stream with pack_cnt=1 -> all counts 0, rd_empty=1, rd_data=0 next cycle.
